// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage.
// Holds opcode constants, instruction field bit positions, the bubble
// encoding, the FSM state type and a sign-extension helper.
package decode_pkg;

    localparam logic [5:0] OP_LOAD  = 6'b001001;
    localparam logic [5:0] OP_STORE = 6'b001000;
    localparam logic [2:0] RR_CLASS = 3'b000;

    // Instruction field bit positions
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int CLS_LO = 29;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS_HI  = 20;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [31:0] BUBBLE_IR = 32'h0;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file, two combinational read ports, one write port.
// Ports:
//   clk                  - clock, write on posedge
//   rd_addr_a/rd_addr_b  - read addresses
//   rd_data_a/rd_data_b  - read data (r0 reads 0, same-cycle write bypassed)
//   wr_en/wr_addr/wr_data - write port; writes to r0 are dropped
// Contents are deliberately not reset.
module regfile_2r1w (
    input  logic        clk,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] mem [32];

    always_ff @(posedge clk) begin
        if (wr_en && wr_addr != 5'd0) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // r0 check comes first so a write-back aimed at r0 is never forwarded.
    assign rd_data_a = (rd_addr_a == 5'd0)                  ? 32'h0   :
                       (wr_en && wr_addr == rd_addr_a)      ? wr_data : mem[rd_addr_a];
    assign rd_data_b = (rd_addr_b == 5'd0)                  ? 32'h0   :
                       (wr_en && wr_addr == rd_addr_b)      ? wr_data : mem[rd_addr_b];

endmodule

// File: rtl/decode.sv
// Decode stage: IF/ID latch, register read, hazard scoreboard, ID/EX outputs.
// Ports:
//   clk, reset (sync, active-low)
//   IR_F, NPC_F       - instruction / next-PC from fetch
//   Flush_D           - squash the instruction held in decode
//   WB_en/WB_rd/WB_data - register write-back (bypassed into reads)
//   Stall_D           - combinational hold request to fetch
//   IR_D, NPC_D, A_D, B_D, Imm_D, Valid_D - registered ID/EX outputs
//
// state    | meaning
// ST_FILL  | two post-reset cycles of bubbles; latch loads on the second
// ST_RUN   | issue latched instruction each cycle
// ST_STALL | source hazard against EX/MEM dest; hold latch, issue bubbles
module decode
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_F,
    input  logic [31:0] NPC_F,
    input  logic        Flush_D,
    input  logic        WB_en,
    input  logic [4:0]  WB_rd,
    input  logic [31:0] WB_data,
    output logic        Stall_D,
    output logic [31:0] IR_D,
    output logic [31:0] NPC_D,
    output logic [31:0] A_D,
    output logic [31:0] B_D,
    output logic [31:0] Imm_D,
    output logic        Valid_D
);

    state_t      state;
    logic        fill_cnt;
    logic [31:0] lat_ir;
    logic [31:0] lat_npc;
    logic        lat_valid;

    // Scoreboard: index 0 = EX, index 1 = MEM
    logic [1:0]  sb_valid;
    logic [4:0]  sb_dest_ex;
    logic [4:0]  sb_dest_mem;

    logic [5:0]  op;
    logic        is_load, is_store, is_rr;
    logic        has_dest, uses_s1, uses_s2;
    logic [4:0]  f_rd, f_rs, f_rt, src_b;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        hazard;

    function automatic logic sb_hit(input logic [4:0] r, input logic [1:0] v,
                                    input logic [4:0] d_ex, input logic [4:0] d_mem);
        return (r != 5'd0) && ((v[0] && d_ex == r) || (v[1] && d_mem == r));
    endfunction

    always_comb begin
        op        = lat_ir[OP_HI:OP_LO];
        is_load   = (op == OP_LOAD);
        is_store  = (op == OP_STORE);
        is_rr     = (lat_ir[OP_HI:CLS_LO] == RR_CLASS);
        f_rd      = lat_ir[RD_HI:RD_LO];
        f_rs      = lat_ir[RS_HI:RS_LO];
        f_rt      = lat_ir[RT_HI:RT_LO];
        has_dest  = is_load | is_rr;
        uses_s1   = is_load | is_store | is_rr;
        uses_s2   = is_store | is_rr;
        src_b     = is_store ? f_rd : f_rt;
        rd_addr_a = is_store ? f_rd : f_rs;
        rd_addr_b = is_rr    ? f_rt : f_rs;
        hazard    = lat_valid &&
                    ((uses_s1 && sb_hit(f_rs,  sb_valid, sb_dest_ex, sb_dest_mem)) ||
                     (uses_s2 && sb_hit(src_b, sb_valid, sb_dest_ex, sb_dest_mem)));
    end

    // A flush overrides any pending hazard.
    assign Stall_D = hazard && !Flush_D;

    regfile_2r1w u_regfile (
        .clk       (clk),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (WB_en),
        .wr_addr   (WB_rd),
        .wr_data   (WB_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_FILL;
            fill_cnt    <= 1'b0;
            lat_ir      <= BUBBLE_IR;
            lat_npc     <= 32'h0;
            lat_valid   <= 1'b0;
            sb_valid    <= 2'b00;
            sb_dest_ex  <= 5'd0;
            sb_dest_mem <= 5'd0;
            IR_D        <= BUBBLE_IR;
            NPC_D       <= 32'h0;
            A_D         <= 32'h0;
            B_D         <= 32'h0;
            Imm_D       <= 32'h0;
            Valid_D     <= 1'b0;
        end else begin
            // Default every cycle: issue a bubble (NPC_D holds) and shift
            // the scoreboard with an invalid EX entry.
            IR_D        <= BUBBLE_IR;
            A_D         <= 32'h0;
            B_D         <= 32'h0;
            Imm_D       <= 32'h0;
            Valid_D     <= 1'b0;
            sb_valid[1] <= sb_valid[0];
            sb_dest_mem <= sb_dest_ex;
            sb_valid[0] <= 1'b0;

            if (Flush_D) begin
                lat_valid <= 1'b0;
                state     <= ST_RUN;
            end else begin
                case (state)
                    ST_FILL: begin
                        fill_cnt <= 1'b1;
                        if (fill_cnt) begin
                            lat_ir    <= IR_F;
                            lat_npc   <= NPC_F;
                            lat_valid <= 1'b1;
                            state     <= ST_RUN;
                        end
                    end
                    default: begin
                        if (hazard) begin
                            state <= ST_STALL;
                        end else begin
                            state <= ST_RUN;
                            if (lat_valid) begin
                                IR_D    <= lat_ir;
                                NPC_D   <= lat_npc;
                                A_D     <= rd_data_a;
                                B_D     <= uses_s2 ? rd_data_b : 32'h0;
                                Imm_D   <= sext16(lat_ir[IMM_HI:IMM_LO]);
                                Valid_D <= 1'b1;
                            end
                            sb_valid[0] <= lat_valid & has_dest;
                            sb_dest_ex  <= f_rd;
                            lat_ir      <= IR_F;
                            lat_npc     <= NPC_F;
                            lat_valid   <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: per-cycle vectors with hand-derived
// expected outputs, queued at drive time and compared after the edge.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_F, NPC_F;
    logic        Flush_D;
    logic        WB_en;
    logic [4:0]  WB_rd;
    logic [31:0] WB_data;
    logic        Stall_D;
    logic [31:0] IR_D, NPC_D, A_D, B_D, Imm_D;
    logic        Valid_D;

    decode dut (
        .clk     (clk),
        .reset   (reset),
        .IR_F    (IR_F),
        .NPC_F   (NPC_F),
        .Flush_D (Flush_D),
        .WB_en   (WB_en),
        .WB_rd   (WB_rd),
        .WB_data (WB_data),
        .Stall_D (Stall_D),
        .IR_D    (IR_D),
        .NPC_D   (NPC_D),
        .A_D     (A_D),
        .B_D     (B_D),
        .Imm_D   (Imm_D),
        .Valid_D (Valid_D)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        valid;
    } out_t;

    typedef struct {
        logic        rst;
        logic [31:0] ir_f;
        logic [31:0] npc_f;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        int          stall;   // -1 = not checked
        out_t        exp;
    } vec_t;

    out_t exp_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] mk_rr(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        return {6'b000000, d, s1, s2, 11'b0};
    endfunction

    function automatic logic [31:0] mk_ld(input logic [4:0] d, input logic [4:0] s, input logic [15:0] imm);
        return {6'b001001, d, s, imm};
    endfunction

    function automatic logic [31:0] mk_st(input logic [4:0] a, input logic [4:0] b, input logic [15:0] imm);
        return {6'b001000, a, b, imm};
    endfunction

    function automatic out_t o(input logic [31:0] ir, input logic [31:0] npc, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm, input logic valid);
        out_t r;
        r.ir = ir; r.npc = npc; r.a = a; r.b = b; r.imm = imm; r.valid = valid;
        return r;
    endfunction

    function automatic out_t bub(input logic [31:0] npc);
        return o(32'h0, npc, 32'h0, 32'h0, 32'h0, 1'b0);
    endfunction

    function automatic vec_t vec(input logic rst, input logic [31:0] ir, input logic [31:0] npc,
                                 input logic flush, input logic wb_en, input logic [4:0] wb_rd,
                                 input logic [31:0] wb_data, input int stall, input out_t exp);
        vec_t t;
        t.rst = rst; t.ir_f = ir; t.npc_f = npc; t.flush = flush;
        t.wb_en = wb_en; t.wb_rd = wb_rd; t.wb_data = wb_data;
        t.stall = stall; t.exp = exp;
        return t;
    endfunction

    task automatic cyc(input vec_t t, input string tag);
        out_t got, want;
        @(negedge clk);
        reset   = t.rst;
        IR_F    = t.ir_f;
        NPC_F   = t.npc_f;
        Flush_D = t.flush;
        WB_en   = t.wb_en;
        WB_rd   = t.wb_rd;
        WB_data = t.wb_data;
        #1;
        if (t.stall >= 0) begin
            n_cmp++;
            if (Stall_D !== t.stall[0]) begin
                n_bad++;
                $display("FAIL %s stall: got %b want %0d", tag, Stall_D, t.stall);
            end
        end
        exp_q.push_back(t.exp);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        got  = o(IR_D, NPC_D, A_D, B_D, Imm_D, Valid_D);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s out: got ir=%h npc=%h a=%h b=%h imm=%h v=%b want ir=%h npc=%h a=%h b=%h imm=%h v=%b",
                     tag, got.ir, got.npc, got.a, got.b, got.imm, got.valid,
                     want.ir, want.npc, want.a, want.b, want.imm, want.valid);
        end
    endtask

    initial begin
        reset = 1'b0; IR_F = 32'h0; NPC_F = 32'h0; Flush_D = 1'b0;
        WB_en = 1'b0; WB_rd = 5'd0; WB_data = 32'h0;

        // Reset cycles preload registers through write-back (regfile not reset).
        tbl.push_back(vec(0, 32'h0, 32'h0, 0, 1, 5'd2, 32'h22,       -1, bub(32'h0)));
        tbl.push_back(vec(0, 32'h0, 32'h0, 0, 1, 5'd3, 32'h33,        0, bub(32'h0)));
        tbl.push_back(vec(0, 32'h0, 32'h0, 0, 1, 5'd7, 32'h77,        0, bub(32'h0)));
        tbl.push_back(vec(0, 32'h0, 32'h0, 0, 1, 5'd0, 32'hFFFFFFFF,  0, bub(32'h0)));
        // Fill: two bubbles, then the RR-ALU issues.
        tbl.push_back(vec(1, 32'h00221800, 32'h100, 0, 0, 5'd0, 32'h0, 0, bub(32'h0)));
        tbl.push_back(vec(1, 32'h00221800, 32'h100, 0, 0, 5'd0, 32'h0, 0, bub(32'h0)));
        tbl.push_back(vec(1, mk_ld(5'd3, 5'd2, 16'h0010), 32'h104, 0, 0, 5'd0, 32'h0, 0,
                          o(32'h00221800, 32'h100, 32'h22, 32'h33, 32'h1800, 1)));
        tbl.push_back(vec(1, mk_rr(5'd4, 5'd3, 5'd3), 32'h108, 0, 0, 5'd0, 32'h0, 0,
                          o(mk_ld(5'd3, 5'd2, 16'h0010), 32'h104, 32'h22, 32'h0, 32'h10, 1)));
        // Load-use: two stall cycles; first one has a simultaneous WB to r3.
        tbl.push_back(vec(1, mk_st(5'd5, 5'd7, 16'h0), 32'h10C, 0, 1, 5'd3, 32'h3333, 1, bub(32'h104)));
        tbl.push_back(vec(1, mk_st(5'd5, 5'd7, 16'h0), 32'h10C, 0, 0, 5'd0, 32'h0,    1, bub(32'h104)));
        tbl.push_back(vec(1, mk_st(5'd5, 5'd7, 16'h0), 32'h10C, 0, 1, 5'd3, 32'h0BADF00D, 0,
                          o(mk_rr(5'd4, 5'd3, 5'd3), 32'h108, 32'h0BADF00D, 32'h0BADF00D, 32'h1800, 1)));
        // STORE reads r5 through the bypass.
        tbl.push_back(vec(1, mk_ld(5'd0, 5'd2, 16'h0), 32'h110, 0, 1, 5'd5, 32'hDEADBEEF, 0,
                          o(mk_st(5'd5, 5'd7, 16'h0), 32'h10C, 32'hDEADBEEF, 32'h77, 32'h0, 1)));
        tbl.push_back(vec(1, mk_rr(5'd6, 5'd0, 5'd0), 32'h114, 0, 0, 5'd0, 32'h0, 0,
                          o(mk_ld(5'd0, 5'd2, 16'h0), 32'h110, 32'h22, 32'h0, 32'h0, 1)));
        // r0 sources after an r0 dest: no stall, reads 0 despite WB r0.
        tbl.push_back(vec(1, mk_ld(5'd8, 5'd2, 16'h0), 32'h118, 0, 1, 5'd0, 32'hFFFFFFFF, 0,
                          o(mk_rr(5'd6, 5'd0, 5'd0), 32'h114, 32'h0, 32'h0, 32'h0, 1)));
        tbl.push_back(vec(1, mk_rr(5'd9, 5'd8, 5'd2), 32'h11C, 0, 0, 5'd0, 32'h0, 0,
                          o(mk_ld(5'd8, 5'd2, 16'h0), 32'h118, 32'h22, 32'h0, 32'h0, 1)));
        // Stall, then flush in the second stall cycle: held instruction dropped.
        tbl.push_back(vec(1, mk_rr(5'd10, 5'd2, 5'd3), 32'h120, 0, 0, 5'd0, 32'h0, 1, bub(32'h118)));
        tbl.push_back(vec(1, mk_rr(5'd10, 5'd2, 5'd3), 32'h120, 1, 0, 5'd0, 32'h0, 0, bub(32'h118)));
        tbl.push_back(vec(1, mk_rr(5'd10, 5'd2, 5'd3), 32'h120, 0, 0, 5'd0, 32'h0, 0, bub(32'h118)));
        tbl.push_back(vec(1, mk_ld(5'd11, 5'd2, 16'h8004), 32'h124, 0, 0, 5'd0, 32'h0, 0,
                          o(mk_rr(5'd10, 5'd2, 5'd3), 32'h120, 32'h22, 32'h0BADF00D, 32'h1800, 1)));

        foreach (tbl[i]) cyc(tbl[i], $sformatf("tbl[%0d]", i));

        // Negative immediate, stall, then reset in the second stall cycle.
        cyc(vec(1, mk_rr(5'd12, 5'd11, 5'd11), 32'h128, 0, 0, 5'd0, 32'h0, 0,
                o(mk_ld(5'd11, 5'd2, 16'h8004), 32'h124, 32'h22, 32'h0, 32'hFFFF8004, 1)), "ld_neg");
        cyc(vec(1, mk_rr(5'd12, 5'd11, 5'd11), 32'h128, 0, 0, 5'd0, 32'h0, 1, bub(32'h124)), "stall1");
        cyc(vec(0, mk_rr(5'd12, 5'd11, 5'd11), 32'h128, 0, 0, 5'd0, 32'h0, 1, bub(32'h0)),   "rst_stall");
        cyc(vec(1, mk_rr(5'd13, 5'd7, 5'd0), 32'h200, 0, 0, 5'd0, 32'h0, 0, bub(32'h0)),     "refill0");
        cyc(vec(1, mk_rr(5'd13, 5'd7, 5'd0), 32'h200, 0, 0, 5'd0, 32'h0, 0, bub(32'h0)),     "refill1");
        cyc(vec(1, 32'h0, 32'h204, 0, 0, 5'd0, 32'h0, 0,
                o(mk_rr(5'd13, 5'd7, 5'd0), 32'h200, 32'h77, 32'h0, 32'h0, 1)),              "r7_keep");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset: sampled on posedge clk, 0 = reset.
REQ-003 SHALL have ports IR_F, input, 32, and NPC_F, input, 32: instruction and next-PC from fetch.
REQ-004 SHALL have port Flush_D, input, 1: taken branch; squash the instruction held in decode.
REQ-005 SHALL have ports WB_en, input, 1; WB_rd, input, 5; WB_data, input, 32: register write-back.
REQ-006 SHALL have port Stall_D, output, 1: hold request to fetch (combinational).
REQ-007 SHALL have ports IR_D, NPC_D, A_D, B_D, Imm_D, output, 32 each; Valid_D, output, 1: registered ID/EX stage outputs.

Function
REQ-008 SHALL decode the following classes:
- LOAD: op[31:26]=001001; dest [25:21]; src [20:16].
- STORE: op=001000; srcs [20:16] and [25:21].
- RR-ALU: [31:29]=000; dest [25:21]; srcs [20:16] and [15:11].
- All other opcodes: no dest, no src.
REQ-009 SHALL contain a 32x32 register file: r0 reads 0; writes to r0 are ignored; write on posedge when WB_en=1.
REQ-010 SHALL bypass write-back: a same-cycle read of WB_rd (nonzero, WB_en=1) SHALL return WB_data.
REQ-011 SHALL hold one instruction in an IF/ID latch (IR, NPC, valid); IR_F is captured at edge t and issued to outputs at edge t+1 at the earliest.
REQ-012 SHALL keep a 2-entry scoreboard of (valid, dest) for the instructions in EX and MEM, shifted every cycle; a bubble shifts in valid=0.
REQ-013 SHALL raise Stall_D when the latched instruction is valid and any nonzero source equals a valid scoreboard dest.
REQ-014 SHALL resolve any stall within 2 cycles.
REQ-015 On stall, SHALL hold the latch and issue a bubble: IR_D=0, Valid_D=0, A_D=B_D=Imm_D=0, NPC_D unchanged.
REQ-016 Without a stall, SHALL issue the latched instruction as follows:
- A_D = reg[IR[25:21]] for STORE, else reg[IR[20:16]];
- B_D = reg[IR[15:11]] for RR-ALU, reg[IR[20:16]] for STORE, else 0;
- Imm_D = sign-extended IR[15:0];
- the latch loads IR_F/NPC_F.
REQ-017 SHALL use FSM states FILL, RUN, STALL.
- FILL: 2 cycles after reset emitting bubbles, latch valid=0; then RUN.
- RUN to STALL when hazard; STALL to RUN when hazard clears.
REQ-018 Flush_D=1 SHALL take priority over stall:
- latch cleared to valid=0 and a bubble issued;
- FSM goes to RUN;
- IR_F is not captured that edge;
- Stall_D SHALL be 0 while Flush_D=1.
REQ-019 SHALL never compare r0 for hazards; bubble IR 0 therefore creates no hazard.
REQ-020 Simultaneous WB to a source and scoreboard match SHALL still stall: scoreboard has priority over bypass.

Reset
REQ-021 On reset=0 at posedge SHALL set:
- IR_D=0, NPC_D=0, A_D=B_D=Imm_D=0, Valid_D=0;
- latch valid=0, scoreboard invalid;
- FSM=FILL, fill count 0.
Register file contents SHALL be unchanged. Reset mid-stall SHALL discard the held instruction.

Structure
REQ-022 A shared package SHALL hold:
- opcodes OP_LOAD=6'b001001, OP_STORE=6'b001000, RR class 3'b000;
- field bit positions;
- BUBBLE_IR=32'h0;
- FSM state encodings.
REQ-023 The register file SHALL be a sub-module regfile_2r1w (2 read, 1 write, internal WB bypass).

Verification
REQ-024 Reset release, then RR-ALU 32'h00221800: Valid_D=0 for 2 cycles (FILL), then the instruction issues.
REQ-025 LOAD r3 followed by RR-ALU using r3 as src: Stall_D=1 for 2 cycles, 2 bubbles issued, then issue with A_D/B_D from WB bypass.
REQ-026 With WB_en=1, WB_rd=5, WB_data=32'hDEADBEEF while STORE reads r5: A_D=32'hDEADBEEF on the next edge.
REQ-027 Flush_D=1 during STALL: next outputs are a bubble, Stall_D=0, FSM=RUN, and the held instruction never appears on IR_D.
REQ-028 Writes to r0 with WB_data=32'hFFFFFFFF, then a read of r0: value 0, and no stall on r0 sources.
REQ-029 reset=0 asserted in the second stall cycle: all outputs 0 next edge, and a prior r7 write still reads back.
